// File: rtl/adder_job_ctrl_if.sv
// -----------------------------------------------------------------------------
// adder_job_ctrl_if
// Bundles the host-endpoint and engine-side signals of adder_job_ctrl.
//   master : host/engine side (drives pipe-in, triggers, engine done/result)
//   slave  : the job controller
// Signals
//   wr_valid/wr_data   pipe-in write strobe and word
//   start_trig         one-cycle start trigger
//   rd_req/rd_data     pipe-out read strobe and registered word
//   done_trig          one-cycle job-done pulse
//   eng_start/eng_din  engine start pulse and packed operand
//   eng_done/eng_dout  engine done pulse and result
//   busy/status        RUN indicator, {ovf_err, start_err, result_ready, armed}
// -----------------------------------------------------------------------------
interface adder_job_ctrl_if #(
   parameter int N_WORDS = 4,
   parameter int WORD_W  = 32,
   parameter int RES_W   = 16
);
   logic                      wr_valid;
   logic [WORD_W-1:0]         wr_data;
   logic                      start_trig;
   logic                      rd_req;
   logic [WORD_W-1:0]         rd_data;
   logic                      done_trig;
   logic                      eng_start;
   logic [N_WORDS*WORD_W-1:0] eng_din;
   logic                      eng_done;
   logic [RES_W-1:0]          eng_dout;
   logic                      busy;
   logic [3:0]                status;

   modport master (
      output wr_valid, wr_data, start_trig, rd_req, eng_done, eng_dout,
      input  rd_data, done_trig, eng_start, eng_din, busy, status
   );

   modport slave (
      input  wr_valid, wr_data, start_trig, rd_req, eng_done, eng_dout,
      output rd_data, done_trig, eng_start, eng_din, busy, status
   );
endinterface

// File: rtl/adder_job_ctrl.sv
// -----------------------------------------------------------------------------
// adder_job_ctrl
// Job sequencer between the host endpoints and the adder_tree_fsm engine.
// Packs N_WORDS pipe-in words into the engine operand (first word = MSB word),
// starts the engine, captures its zero-extended result, pulses done_trig and
// serves the result to pipe-out MSB word first. Protocol misuse sets sticky
// error bits (ovf_err for writes outside IDLE/LOAD, start_err for a start
// outside ARMED).
// Ports
//   clk   : single clock (okClk domain)
//   rstn  : asynchronous active-low reset
//   clr   : synchronous soft clear, same effect as reset
//   bus   : adder_job_ctrl_if.slave (pipe, triggers, engine, busy/status)
// Build option
//   AUTO_START_EN : engine starts automatically on the N_WORDS-th write;
//                   start_trig is ignored and start_err is never set.
// -----------------------------------------------------------------------------
module adder_job_ctrl #(
   parameter int N_WORDS = 4,
   parameter int WORD_W  = 32,
   parameter int RES_W   = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   adder_job_ctrl_if.slave  bus
);
   localparam int FRAME_W = N_WORDS * WORD_W;
   localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_RUN, S_RESULT} state_t;

   state_t              state;
   logic [WORD_W-1:0]   op_w  [N_WORDS];
   logic [WORD_W-1:0]   res_w [N_WORDS];
   logic [WORD_W-1:0]   ext_w [N_WORDS];
   logic [FRAME_W-1:0]  dout_ext;
   logic [CNT_W-1:0]    wr_cnt, rd_cnt;
   logic [CNT_W-1:0]    wr_slot, rd_slot;
   logic [WORD_W-1:0]   rd_data_q;
   logic                eng_start_q, done_q;
   logic                ovf_err, start_err;
   logic                fill_ok, last_wr, last_rd;

   // Word k of a frame lives in slot N_WORDS-1-k, so counts map to slots downwards.
   assign wr_slot = CNT_W'(N_WORDS - 1) - wr_cnt;
   assign rd_slot = CNT_W'(N_WORDS - 1) - rd_cnt;
   assign last_wr = (wr_cnt == CNT_W'(N_WORDS - 1));
   assign last_rd = (rd_cnt == CNT_W'(N_WORDS - 1));
   assign fill_ok = (state == S_IDLE) || (state == S_LOAD);

   assign dout_ext = FRAME_W'(bus.eng_dout);

   for (genvar g = 0; g < N_WORDS; g++) begin : g_pack
      assign bus.eng_din[g*WORD_W +: WORD_W] = op_w[g];
      assign ext_w[g] = dout_ext[g*WORD_W +: WORD_W];
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.done_trig = done_q;
   assign bus.eng_start = eng_start_q;
   assign bus.busy      = (state == S_RUN);
   assign bus.status    = {ovf_err, start_err, state == S_RESULT, state == S_ARMED};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_IDLE;
         op_w        <= '{default: '0};
         res_w       <= '{default: '0};
         wr_cnt      <= '0;
         rd_cnt      <= '0;
         rd_data_q   <= '0;
         eng_start_q <= 1'b0;
         done_q      <= 1'b0;
         ovf_err     <= 1'b0;
         start_err   <= 1'b0;
      end else if (clr) begin
         // Soft clear; a late eng_done after this is ignored because state leaves RUN.
         state       <= S_IDLE;
         op_w        <= '{default: '0};
         res_w       <= '{default: '0};
         wr_cnt      <= '0;
         rd_cnt      <= '0;
         rd_data_q   <= '0;
         eng_start_q <= 1'b0;
         done_q      <= 1'b0;
         ovf_err     <= 1'b0;
         start_err   <= 1'b0;
      end else begin
         eng_start_q <= 1'b0;
         done_q      <= 1'b0;

         if (bus.wr_valid) begin
            if (fill_ok) begin
               op_w[wr_slot] <= bus.wr_data;
               if (last_wr) begin
                  wr_cnt <= '0;
                  state  <= S_ARMED;
`ifdef AUTO_START_EN
                  eng_start_q <= 1'b1;
`endif
               end else begin
                  wr_cnt <= wr_cnt + 1'b1;
                  state  <= S_LOAD;
               end
            end else begin
               ovf_err <= 1'b1;
            end
         end

`ifdef AUTO_START_EN
         // The start pulse was already issued with the filling write; ARMED lasts one cycle.
         if (state == S_ARMED) state <= S_RUN;
`else
         // Start is judged on the current state, so a start coinciding with the
         // filling write sees LOAD and is rejected.
         if (bus.start_trig) begin
            if (state == S_ARMED) begin
               eng_start_q <= 1'b1;
               state       <= S_RUN;
            end else begin
               start_err <= 1'b1;
            end
         end
`endif

         if ((state == S_RUN) && bus.eng_done) begin
            res_w  <= ext_w;
            rd_cnt <= '0;
            done_q <= 1'b1;
            state  <= S_RESULT;
         end

         if (bus.rd_req) begin
            if (state == S_RESULT) begin
               rd_data_q <= res_w[rd_slot];
               if (last_rd) begin
                  rd_cnt <= '0;
                  state  <= S_IDLE;
                  op_w   <= '{default: '0};
               end else begin
                  rd_cnt <= rd_cnt + 1'b1;
               end
            end else begin
               rd_data_q <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_adder_job_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_job_ctrl
// Self-checking bench for adder_job_ctrl: directed job scenarios followed by
// randomized traffic, compared every cycle against a job-level reference model.
// -----------------------------------------------------------------------------
module tb_adder_job_ctrl;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int R  = 16;
   localparam int FW = N * W;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic clr = 1'b0;

   adder_job_ctrl_if #(.N_WORDS(N), .WORD_W(W), .RES_W(R)) bus ();

   adder_job_ctrl #(.N_WORDS(N), .WORD_W(W), .RES_W(R)) dut (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clr),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- job-level reference model ----------------
   logic [W-1:0]  m_words[$];   // words accepted for the current job, in write order
   bit            m_run;        // engine job in flight
   bit            m_res_v;      // result available for reading
   int            m_reads;
   logic [FW-1:0] m_res;
   logic [W-1:0]  m_rd;
   bit            m_ovf, m_serr, m_start, m_done;

   task automatic model_reset();
      m_words.delete();
      m_run = 0; m_res_v = 0; m_reads = 0; m_res = '0; m_rd = '0;
      m_ovf = 0; m_serr = 0; m_start = 0; m_done = 0;
   endtask

   function automatic bit m_armed();
      return (m_words.size() == N) && !m_run && !m_res_v;
   endfunction

   function automatic logic [FW-1:0] m_operand();
      logic [FW-1:0] op = '0;
      foreach (m_words[k]) op |= FW'(m_words[k]) << (W * (N - 1 - k));
      return op;
   endfunction

   task automatic model_step(input bit wr, input logic [W-1:0] d, input bit st,
                             input bit rd, input bit ed, input logic [R-1:0] eo, input bit cl);
      bit pre_run   = m_run;
      bit pre_res   = m_res_v;
      bit pre_fill  = (m_words.size() < N) && !m_run && !m_res_v;
      bit pre_armed = m_armed();
      m_start = 0;
      m_done  = 0;
      if (cl) begin
         model_reset();
      end else begin
         if (wr) begin
            if (pre_fill) begin
               m_words.push_back(d);
`ifdef AUTO_START_EN
               if (m_words.size() == N) m_start = 1;
`endif
            end else begin
               m_ovf = 1;
            end
         end
`ifdef AUTO_START_EN
         if (pre_armed) m_run = 1;
`else
         if (st) begin
            if (pre_armed) begin
               m_run = 1;
               m_start = 1;
            end else begin
               m_serr = 1;
            end
         end
`endif
         if (ed && pre_run) begin
            m_run = 0; m_res_v = 1; m_res = FW'(eo); m_reads = 0; m_done = 1;
         end
         if (rd) begin
            if (pre_res) begin
               m_rd = W'(m_res >> (W * (N - 1 - m_reads)));
               m_reads++;
               if (m_reads == N) begin
                  m_res_v = 0; m_reads = 0; m_words.delete();
               end
            end else begin
               m_rd = '0;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/eng_start"}, FW'(bus.eng_start), FW'(m_start));
      check({tag, "/done_trig"}, FW'(bus.done_trig), FW'(m_done));
      check({tag, "/busy"},      FW'(bus.busy),      FW'(m_run));
      check({tag, "/status"},    FW'(bus.status),    FW'({m_ovf, m_serr, m_res_v, m_armed()}));
      check({tag, "/eng_din"},   bus.eng_din,        m_operand());
      check({tag, "/rd_data"},   FW'(bus.rd_data),   FW'(m_rd));
   endtask

   // One clock cycle with the given inputs, then model update and full check.
   task automatic step(input string tag, input bit wr, input logic [W-1:0] d, input bit st,
                       input bit rd, input bit ed, input logic [R-1:0] eo, input bit cl);
      bus.wr_valid = wr; bus.wr_data = d; bus.start_trig = st;
      bus.rd_req = rd; bus.eng_done = ed; bus.eng_dout = eo; clr = cl;
      @(posedge clk);
      #1;
      bus.wr_valid = 0; bus.start_trig = 0; bus.rd_req = 0; bus.eng_done = 0; clr = 0;
      model_step(wr, d, st, rd, ed, eo, cl);
      check_all(tag);
   endtask

   task automatic do_wr(input string tag, input logic [W-1:0] d);
      step(tag, 1, d, 0, 0, 0, '0, 0);
   endtask
   task automatic do_start(input string tag);
      step(tag, 0, '0, 1, 0, 0, '0, 0);
   endtask
   task automatic do_idle(input string tag);
      step(tag, 0, '0, 0, 0, 0, '0, 0);
   endtask
   task automatic do_done(input string tag, input logic [R-1:0] eo);
      step(tag, 0, '0, 0, 0, 1, eo, 0);
   endtask
   task automatic do_rd(input string tag);
      step(tag, 0, '0, 0, 1, 0, '0, 0);
   endtask
   task automatic do_clr(input string tag);
      step(tag, 0, '0, 0, 0, 0, '0, 1);
   endtask

   initial begin
      bus.wr_valid = 0; bus.wr_data = '0; bus.start_trig = 0;
      bus.rd_req = 0; bus.eng_done = 0; bus.eng_dout = '0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rstn = 1'b1;

      // Basic job 1..4, result 0xAA
      for (int i = 1; i <= N; i++) do_wr("t1_wr", W'(i));
      check("t1_din", bus.eng_din, 128'h00000001_00000002_00000003_00000004);
      do_start("t1_start");
`ifndef AUTO_START_EN
      check("t1_eng_start", FW'(bus.eng_start), FW'(1));
`endif
      do_idle("t1_idle");
      do_done("t1_done", 16'h00AA);
      check("t1_done_trig", FW'(bus.done_trig), FW'(1));
      for (int i = 0; i < N; i++) do_rd("t1_rd");
      check("t1_last_word", FW'(bus.rd_data), FW'(32'h000000AA));
      check("t1_status_idle", FW'(bus.status), FW'(4'b0000));

`ifndef AUTO_START_EN
      // Early start is rejected, fourth write arms
      for (int i = 0; i < 3; i++) do_wr("t2_wr", $urandom);
      do_start("t2_early_start");
      check("t2_status_err", FW'(bus.status), FW'(4'b0100));
      do_wr("t2_wr4", $urandom);
      check("t2_status_armed", FW'(bus.status), FW'(4'b0101));
      do_clr("t2_clr");
      for (int i = 0; i < 3; i++) do_wr("t2b_wr", $urandom);
      do_idle("t2b_idle");
      do_start("t2b_start");
      do_wr("t2b_wr4", $urandom);
      check("t2b_status", FW'(bus.status), FW'(4'b0101));
      do_clr("t2b_clr");
`endif

      // Overflow write, sticky through a full job until clr
      for (int i = 0; i < N; i++) do_wr("t3_wr", $urandom);
      do_wr("t3_wr5", 32'hDEADBEEF);
      check("t3_ovf", FW'(bus.status[3]), FW'(1));
      do_start("t3_start");
      do_done("t3_done", R'($urandom));
      for (int i = 0; i < N; i++) do_rd("t3_rd");
      check("t3_ovf_sticky", FW'(bus.status[3]), FW'(1));
      do_clr("t3_clr");
      check("t3_status_clr", FW'(bus.status), FW'(4'b0000));

      // clr mid-RUN, late eng_done ignored
      for (int i = 0; i < N; i++) do_wr("t4_wr", $urandom);
      do_start("t4_start");
      do_idle("t4_idle");
      do_clr("t4_clr");
      do_done("t4_late_done", 16'h1234);
      check("t4_no_done", FW'(bus.done_trig), FW'(0));
      check("t4_din_zero", bus.eng_din, '0);
      check("t4_status", FW'(bus.status), FW'(4'b0000));

      // Async reset mid-RESULT after two reads
      for (int i = 0; i < N; i++) do_wr("t5_wr", $urandom);
      do_start("t5_start");
      do_done("t5_done", 16'hBEEF);
      do_rd("t5_rd");
      do_rd("t5_rd");
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      check_all("t5_async_rst");
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < N; i++) do_wr("t5b_wr", $urandom);
      do_start("t5b_start");
      do_done("t5b_done", 16'hC3A5);
      for (int i = 0; i < N; i++) do_rd("t5b_rd");
      check("t5b_last_word", FW'(bus.rd_data), FW'(32'h0000C3A5));

`ifdef AUTO_START_EN
      // Automatic start one cycle after the filling write; start_trig ignored
      do_clr("t6_clr");
      for (int i = 0; i < N - 1; i++) do_wr("t6_wr", $urandom);
      do_start("t6_trig_ignored");
      check("t6_no_start", FW'(bus.eng_start), FW'(0));
      do_wr("t6_wr4", $urandom);
      check("t6_auto_start", FW'(bus.eng_start), FW'(1));
      do_start("t6_trig_armed");
      check("t6_single_pulse", FW'(bus.eng_start), FW'(0));
      check("t6_no_serr", FW'(bus.status[2]), FW'(0));
      do_clr("t6_clr2");
`endif

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         step("rand",
              ($urandom % 3) == 0, $urandom,
              ($urandom % 8) == 0,
              ($urandom % 3) == 0,
              ($urandom % 4) == 0, R'($urandom),
              ($urandom % 64) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
